// File: rtl/dadda_24_arbiter_if.sv
// Bundle of the request and result channels around the shared multiplier.
//
// Parameters
//   NUM_REQ  number of requester ports
//   ID_W     width of the result tag
//
// Signals
//   req_valid  [NUM_REQ]     requester i presents operands
//   req_ready  [NUM_REQ]     requester i accepted on this edge
//   req_a      [NUM_REQ*24]  operand A, slice i = [24*i+23:24*i]
//   req_b      [NUM_REQ*24]  operand B, same slicing
//   res_valid                res_data/res_id hold a product
//   res_ready                consumer takes the product
//   res_data   [47]          product
//   res_id     [ID_W]        index of the requester that issued it
//   busy                     arbiter not idle
//
// Modports
//   master  requesters + result consumer
//   slave   the arbiter
interface dadda_24_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*24-1:0] req_a;
  logic [NUM_REQ*24-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [46:0]           res_data;
  logic [ID_W-1:0]       res_id;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );

endinterface

// File: rtl/dadda_24_arbiter.sv
// Round-robin arbiter sharing one combinational 24x24 Dadda multiplier
// between NUM_REQ requesters, with registered operands and a registered,
// tagged result channel.
//
// Ports
//   clk     clock, rising edge
//   rst_n   asynchronous reset, active low
//   bus     dadda_24_arbiter_if.slave (request/result channels, busy)
//
// Parameters
//   NUM_REQ  requester ports (2..8)
//   ID_W     result tag width, >= clog2(NUM_REQ)
//
// Build option
//   DADDA_ARB_ZERO_BYPASS_EN  when defined, an accepted op with a zero
//   operand loads a zero result directly on the accept edge (1-edge latency)
//   and never touches the multiplier inputs. When undefined, zero operands
//   take the normal 2-edge path.

// Combinational 24x24 multiplier. Partial products are reduced with 3:2
// compressors following the Dadda height sequence 24-19-13-9-6-4-3-2, then
// a single carry-propagate add. Output is the low 47 bits of the product.
module dadda_24 (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [46:0] mul_result
);

  function automatic int stage_height(input int s);
    case (s)
      0:       return 19;
      1:       return 13;
      2:       return 9;
      3:       return 6;
      4:       return 4;
      5:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [46:0] dadda_mul(input logic [23:0] x, input logic [23:0] y);
    logic [47:0] rows [24];
    logic [47:0] nxt  [24];
    int n;
    int k;
    for (int i = 0; i < 24; i++) begin
      rows[i] = y[i] ? (48'(x) << i) : 48'd0;
    end
    n = 24;
    for (int s = 0; s < 7; s++) begin
      // each compressor turns three rows into two, so k of them
      // take the stack from n rows down to the next Dadda height
      k = n - stage_height(s);
      for (int i = 0; i < 24; i++) begin
        nxt[i] = 48'd0;
      end
      for (int j = 0; j < 8; j++) begin
        if (j < k) begin
          nxt[2*j]   = rows[3*j] ^ rows[3*j+1] ^ rows[3*j+2];
          nxt[2*j+1] = ((rows[3*j] & rows[3*j+1]) |
                        (rows[3*j] & rows[3*j+2]) |
                        (rows[3*j+1] & rows[3*j+2])) << 1;
        end
      end
      // rows not consumed by a compressor pass straight down
      for (int i = 0; i < 24; i++) begin
        if (i >= 3*k && i < n) begin
          nxt[i-k] = rows[i];
        end
      end
      rows = nxt;
      n = stage_height(s);
    end
    return 47'(rows[0] + rows[1]);
  endfunction

  assign mul_result = dadda_mul(a, b);

endmodule

module dadda_24_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic              clk,
  input logic              rst_n,
  dadda_24_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef DADDA_ARB_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  // state | meaning
  // IDLE  | no op in flight, ready to accept
  // MUL   | operands registered, multiplier evaluating
  // DONE  | product held on the result channel until popped
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_id;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [23:0]        gnt_a;
  logic [23:0]        gnt_b;

  logic any_req;
  logic can_accept;
  logic accept;
  logic zero_op;
  logic bypass;

  logic [23:0]     op_a;
  logic [23:0]     op_b;
  logic [ID_W-1:0] op_id;
  logic [46:0]     mul_result;

  logic            res_valid_q;
  logic [46:0]     res_data_q;
  logic [ID_W-1:0] res_id_q;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin : grant_search
    int idx;
    idx       = 0;
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_found  = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PTR_W'(idx);
      end
    end
  end

  assign gnt_id  = ID_W'(gnt_idx);
  assign ptr_nxt = PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
  assign gnt_a   = bus.req_a[24*gnt_idx +: 24];
  assign gnt_b   = bus.req_b[24*gnt_idx +: 24];

  assign any_req    = gnt_found;
  assign can_accept = (state == IDLE) | ((state == DONE) & bus.res_ready);
  // rst_n keeps req_ready low while reset is asserted even though the
  // state register already reads IDLE
  assign accept     = can_accept & any_req & rst_n;
  assign zero_op    = (gnt_a == 24'd0) | (gnt_b == 24'd0);
  assign bypass     = ZERO_BYPASS & accept & zero_op;

  assign bus.req_ready = grant & {NUM_REQ{accept}};
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state != IDLE);

  dadda_24 u_mul (
    .a          (op_a),
    .b          (op_b),
    .mul_result (mul_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = bypass ? DONE : MUL;
        end
      end
      MUL: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          if (accept) begin
            state_nxt = bypass ? DONE : MUL;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= ptr_nxt;
      end
      if (accept && !bypass) begin
        op_a  <= gnt_a;
        op_b  <= gnt_b;
        op_id <= gnt_id;
      end
      if (state == MUL) begin
        res_data_q  <= mul_result;
        res_id_q    <= op_id;
        res_valid_q <= 1'b1;
      end else if (bypass) begin
        // a pop and a bypass load on the same edge keep res_valid high
        res_data_q  <= '0;
        res_id_q    <= gnt_id;
        res_valid_q <= 1'b1;
      end else if ((state == DONE) && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dadda_24_arbiter.sv
module tb_dadda_24_arbiter;

  localparam int NR = 4;
  localparam int IW = 2;
`ifdef DADDA_ARB_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dadda_24_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

  dadda_24_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // requester side
  bit          pend [NR];
  logic [23:0] pa   [NR];
  logic [23:0] pb   [NR];

  // reference model: one op slot, round-robin pointer, expected result
  bit          occ;
  int          rr_m;
  int          vis_at;
  logic [46:0] exp_data;
  int          exp_id;
  int          now;

  // last negedge observation
  logic [NR-1:0] obs_ready;
  logic          obs_valid;
  logic [46:0]   obs_data;
  logic [IW-1:0] obs_id;
  logic          obs_busy;

  int          pop_ids  [$];
  logic [46:0] pop_data [$];
  int          pop_now  [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [46:0] prod(input logic [23:0] a, input logic [23:0] b);
    return 47'({24'd0, a} * {24'd0, b});
  endfunction

  // nearest valid port at or after the pointer, by circular distance
  function automatic int pick(input logic [NR-1:0] v, input int rr);
    int best;
    int g;
    int d;
    best = NR;
    g = -1;
    for (int i = 0; i < NR; i++) begin
      d = (i - rr + NR) % NR;
      if (v[i] && d < best) begin
        best = d;
        g = i;
      end
    end
    return g;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_a[24*i +: 24] = pa[i];
      bus.req_b[24*i +: 24] = pb[i];
    end
  endtask

  task automatic cycle();
    logic [NR-1:0] er;
    int g;
    bit vis;
    bit can;
    @(negedge clk);
    obs_ready = bus.req_ready;
    obs_valid = bus.res_valid;
    obs_data  = bus.res_data;
    obs_id    = bus.res_id;
    obs_busy  = bus.busy;
    vis = occ && (now >= vis_at);
    check("res_valid", obs_valid, vis);
    check("busy", obs_busy, occ);
    if (vis) begin
      check("res_data", obs_data, exp_data);
      check("res_id", obs_id, exp_id);
    end
    g = pick(bus.req_valid, rr_m);
    can = !occ || (vis && bus.res_ready);
    er = '0;
    if (can && g >= 0) er[g] = 1'b1;
    check("req_ready", obs_ready, er);
    if (obs_valid && bus.res_ready) begin
      pop_ids.push_back(int'(obs_id));
      pop_data.push_back(obs_data);
      pop_now.push_back(now);
    end
    @(posedge clk);
    #1;
    if (vis && bus.res_ready) occ = 1'b0;
    if (can && g >= 0) begin
      occ = 1'b1;
      rr_m = (g + 1) % NR;
      exp_data = prod(pa[g], pb[g]);
      exp_id = g;
      vis_at = now + (((pa[g] == 24'd0) || (pb[g] == 24'd0)) ? ZLAT : 2);
      pend[g] = 1'b0;
    end
    now++;
    drive();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    drive();
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    occ = 1'b0;
    rr_m = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    drive();
    bus.res_ready = 1'b1;
    repeat (4) cycle();
  endtask

  task automatic latency_run(input string tag, input int exp_lat, input logic [46:0] exp_val, input int port);
    int n0;
    int acc;
    int vld;
    int pulses;
    n0 = pop_ids.size();
    acc = -1;
    vld = -1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (obs_ready[port]) begin
        pulses++;
        if (acc < 0) acc = now - 1;
      end
      if (obs_valid && vld < 0) vld = now - 1;
    end
    check({tag, "_ready_pulses"}, pulses, 1);
    check({tag, "_latency"}, vld - acc, exp_lat);
    check({tag, "_popped"}, pop_ids.size() - n0, 1);
    if (pop_ids.size() > n0) begin
      check({tag, "_data"}, pop_data[n0], exp_val);
      check({tag, "_id"}, pop_ids[n0], port);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      pa[i] = '0;
      pb[i] = '0;
    end
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ready = 1'b0;
    occ = 1'b0;
    rr_m = 0;
    vis_at = 0;
    exp_data = '0;
    exp_id = 0;
    now = 0;

    // reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    // reset in the middle of a multiply
    pend[0] = 1'b1; pa[0] = 24'd7; pb[0] = 24'd9;
    bus.res_ready = 1'b1;
    drive();
    cycle();
    pend[1] = 1'b1; pa[1] = 24'd11; pb[1] = 24'd13;
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_res_valid", bus.res_valid, 0);
    check("t1_res_data", bus.res_data, 0);
    check("t1_res_id", bus.res_id, 0);
    check("t1_busy", bus.busy, 0);
    check("t1_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    check("t1_hold_res_valid", bus.res_valid, 0);
    pend[1] = 1'b0;
    drive();
    rst_n = 1'b1;
    occ = 1'b0;
    rr_m = 0;
    repeat (4) cycle();

    // single op on port 0
    pend[0] = 1'b1; pa[0] = 24'd3; pb[0] = 24'd5;
    drive();
    latency_run("t2", 2, 47'd15, 0);

    // round robin with all ports valid
    apply_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b1;
      pa[i] = 24'(i + 1);
      pb[i] = 24'h000FA0 + 24'(i);
    end
    drive();
    n0 = pop_ids.size();
    for (int k = 0; k < 20; k++) begin
      cycle();
      for (int i = 0; i < NR; i++) pend[i] = 1'b1;
      drive();
    end
    check("t3_enough_pops", (pop_ids.size() - n0) >= 8, 1);
    for (int k = 0; k < 8; k++) begin
      if (n0 + k + 1 < pop_ids.size()) begin
        check("t3_order", pop_ids[n0+k], k % NR);
        check("t3_spacing", pop_now[n0+k+1] - pop_now[n0+k], 2);
      end
    end
    if (pop_ids.size() > n0 + 1) check("t3_port1_data", pop_data[n0+1], 47'h001F42);

    // backpressure
    drain();
    pend[0] = 1'b1; pa[0] = 24'h000FA0; pb[0] = 24'h000FA1;
    bus.res_ready = 1'b0;
    drive();
    repeat (3) cycle();
    check("t4_valid", obs_valid, 1);
    for (int i = 1; i < NR; i++) begin
      pend[i] = 1'b1;
      pa[i] = 24'($urandom);
      pb[i] = 24'($urandom);
    end
    drive();
    repeat (5) begin
      cycle();
      check("t4_hold_data", obs_data, 47'hF433A0);
      check("t4_ready_low", obs_ready, 0);
      check("t4_busy", obs_busy, 1);
    end
    bus.res_ready = 1'b1;
    cycle();
    check("t4_pop_grant", obs_ready, 4'b0010);
    check("t4_pop_valid", obs_valid, 1);

    // boundary operands and a lone requester on port 2
    drain();
    pend[2] = 1'b1; pa[2] = 24'hFFFFFF; pb[2] = 24'd1;
    drive();
    latency_run("t5", 2, 47'h0000FFFFFF, 2);
    drain();
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b1;
      pa[i] = 24'($urandom);
      pb[i] = 24'($urandom);
    end
    drive();
    cycle();
    check("t5_next_grant", obs_ready, 4'b1000);

    // zero operand
    drain();
    pend[0] = 1'b1; pa[0] = 24'd0; pb[0] = 24'h123456;
    drive();
    latency_run("t6", ZLAT, 47'd0, 0);
    drain();

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom_range(2) == 0)) begin
          pend[i] = 1'b1;
          pa[i] = 24'($urandom);
          pb[i] = 24'($urandom);
          case ($urandom_range(5))
            0: pa[i] = 24'd0;
            1: pb[i] = 24'd0;
            2: begin pa[i] = 24'hFFFFFF; pb[i] = 24'hFFFFFF; end
            default: ;
          endcase
        end
      end
      bus.res_ready = ($urandom_range(3) != 0);
      drive();
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
